gpio_in_debounce: RTL

Input-side companion to the LED output path on the Alta FPGA: takes raw pin levels from `GENERIC_IOB` instances configured with `INPUT_USED(1)` and `OUTPUT_USED(0)`. Each bit passes through a synchronizer and a per-bit debounce filter. The block produces clean levels, one-cycle rise/fall pulses, and an accumulated change event behind a valid/ready handshake. It sits between the input IOBs and user logic, for example the LED driver.

---
 rtl/gpio_in_debounce_if.sv | 25 ++
 rtl/gpio_in_debounce.sv | 115 +++++++++++
 2 files changed

// File: rtl/gpio_in_debounce_if.sv
// rtl/gpio_in_debounce_if.sv - change-event handshake between the input debouncer and its consumer
interface gpio_in_debounce_if #(
   parameter int WIDTH = 8
);
   logic             evt_valid_o;
   logic             evt_ready_i;
   logic [WIDTH-1:0] evt_bits_o;
   logic             evt_overrun_o;

   // Producer side: the debouncer presents pending changes
   modport master (
      output evt_valid_o,
      output evt_bits_o,
      output evt_overrun_o,
      input  evt_ready_i
   );

   // Consumer side: user logic accepts pending changes
   modport slave (
      input  evt_valid_o,
      input  evt_bits_o,
      input  evt_overrun_o,
      output evt_ready_i
   );
endinterface

// File: rtl/gpio_in_debounce.sv
// rtl/gpio_in_debounce.sv - per-bit synchronizer, debounce filter, edge pulses and change-event accumulator
module gpio_in_debounce #(
   parameter int WIDTH           = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [WIDTH-1:0]          pin_i,
   output logic [WIDTH-1:0]          state_o,
   output logic [WIDTH-1:0]          rise_o,
   output logic [WIDTH-1:0]          fall_o,
   gpio_in_debounce_if.master        evt
);
   localparam int              CW      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_d [SYNC_STAGES];
   logic [CW-1:0]    cnt_q  [WIDTH];
   logic [CW-1:0]    cnt_d  [WIDTH];
   logic [WIDTH-1:0] state_q, state_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             ovr_q, ovr_d;
   logic             evt_valid_q, evt_valid_d;
   logic [WIDTH-1:0] sync;
   logic [WIDTH-1:0] chg;
   logic             accept;

   assign sync   = sync_q[SYNC_STAGES-1];
   assign chg    = rise_q | fall_q;
   assign accept = evt_valid_q & evt.evt_ready_i;

   // Synchronizer shift chain: the raw pin enters stage 0, each stage copies the previous one
   always_comb begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
         sync_d[s] = '0;
      end
      sync_d[0] = pin_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
         sync_d[s] = sync_q[s-1];
      end
   end

   // Debounce filter: a bit's level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples
   always_comb begin
      state_d = state_q;
      rise_d  = '0;
      fall_d  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (sync[i] != state_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               state_d[i] = sync[i];
               rise_d[i]  = sync[i];
               fall_d[i]  = ~sync[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Event accumulator: an accept restarts the mask from this cycle's changes so none are dropped
   always_comb begin
      if (accept) begin
         acc_d = chg;
         ovr_d = 1'b0;
      end else begin
         acc_d = acc_q | chg;
         ovr_d = ovr_q | (|(acc_q & chg));
      end
      evt_valid_d = |acc_d;
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= '0;
         end
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
         state_q     <= '0;
         rise_q      <= '0;
         fall_q      <= '0;
         acc_q       <= '0;
         ovr_q       <= 1'b0;
         evt_valid_q <= 1'b0;
      end else begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_d[s];
         end
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         state_q     <= state_d;
         rise_q      <= rise_d;
         fall_q      <= fall_d;
         acc_q       <= acc_d;
         ovr_q       <= ovr_d;
         evt_valid_q <= evt_valid_d;
      end
   end

   assign state_o           = state_q;
   assign rise_o            = rise_q;
   assign fall_o            = fall_q;
   assign evt.evt_valid_o   = evt_valid_q;
   assign evt.evt_bits_o    = acc_q;
   assign evt.evt_overrun_o = ovr_q;
endmodule
